// File: rtl/serial_pkg.sv
// Shared types and helpers for the parametrised serial-to-parallel converter.
package serial_pkg;

    // Link alignment state.
    typedef enum logic [1:0] {
        INIT   = 2'd0,
        SYNC   = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    // Default alignment/idle word (K28.5).
    localparam logic [7:0] K28_5_COMMA = 8'hBC;

    // Width of a counter that must hold the values 0..n.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sp_shift_align.sv
// Shift register, word bit counter and comma comparator for the deserialiser.
// o_hit_c is the comma match gated so a search only considers bits received
// after the last reset or flush; o_match_c is the raw compare used to classify
// aligned words.
module sp_shift_align
    import serial_pkg::*;
#(
    parameter int unsigned      WIDTH = 8,
    parameter logic [WIDTH-1:0] COMMA = WIDTH'(K28_5_COMMA)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_data,
    input  logic             i_realign,
    input  logic             i_flush,
    output logic [WIDTH-1:0] o_word_c,
    output logic             o_boundary_c,
    output logic             o_match_c,
    output logic             o_hit_c
);

    localparam int unsigned BW = $clog2(WIDTH);

    logic [WIDTH-2:0] r_shift;
    logic [BW-1:0]    r_bit_cnt;
    logic [BW-1:0]    r_fill;

    assign o_word_c     = {r_shift, i_data};
    assign o_boundary_c = (r_bit_cnt == BW'(WIDTH - 1));
    assign o_match_c    = (o_word_c == COMMA);
    assign o_hit_c      = o_match_c && (r_fill == BW'(WIDTH - 1));

    // Shift in one bit per clock, MSB first.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_shift <= '0;
        end else begin
            r_shift <= {r_shift[WIDTH-3:0], i_data};
        end
    end

    // Bit position within the current word; realign restarts at bit 0.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_bit_cnt <= '0;
        end else if (i_realign || o_boundary_c) begin
            r_bit_cnt <= '0;
        end else begin
            r_bit_cnt <= r_bit_cnt + BW'(1);
        end
    end

    // Number of fresh bits held in the shift register, saturating at WIDTH-1.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_fill <= '0;
        end else if (i_flush) begin
            r_fill <= '0;
        end else if (r_fill != BW'(WIDTH - 1)) begin
            r_fill <= r_fill + BW'(1);
        end
    end

endmodule

// File: rtl/serial_paralelo_param.sv
// Parametrised MSB-first serial-to-parallel converter with comma alignment.
// Optional loss-of-sync detection is enabled by defining SERIAL_PARALELO_LOS_EN.
module serial_paralelo_param
    import serial_pkg::*;
#(
    parameter int unsigned      WIDTH      = 8,
    parameter logic [WIDTH-1:0] COMMA      = WIDTH'(K28_5_COMMA),
    parameter int unsigned      SYNC_COUNT = 4,
    parameter int unsigned      MAX_GAP    = 64
) (
    input  logic                          clk_32f,
    input  logic                          reset,
    input  logic                          data_in,
    output logic [WIDTH-1:0]              data_out,
    output logic                          valid_out,
    output logic                          word_strobe,
    output logic                          active,
    output logic [cnt_w(SYNC_COUNT)-1:0]  comma_cnt
);

    localparam int unsigned CW = cnt_w(SYNC_COUNT);

    if (WIDTH < 4) begin : g_bad_width
        $error("serial_paralelo_param: WIDTH must be at least 4");
    end
    if (SYNC_COUNT < 1) begin : g_bad_sync
        $error("serial_paralelo_param: SYNC_COUNT must be at least 1");
    end
    if (MAX_GAP < 1) begin : g_bad_gap
        $error("serial_paralelo_param: MAX_GAP must be at least 1");
    end

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_data_out;
    logic [WIDTH-1:0] w_data_nxt;
    logic             r_valid;
    logic             w_valid_nxt;
    logic             r_strobe;
    logic             w_strobe_nxt;
    logic             r_active;
    logic             w_active_nxt;
    logic [CW-1:0]    r_comma_cnt;
    logic [CW-1:0]    w_cnt_nxt;

    logic [WIDTH-1:0] w_word;
    logic             w_boundary;
    logic             w_match;
    logic             w_hit;
    logic             w_realign;
    logic             w_flush;

`ifdef SERIAL_PARALELO_LOS_EN
    localparam int unsigned GW = cnt_w(MAX_GAP);
    logic [GW-1:0] r_gap;
    logic [GW-1:0] w_gap_nxt;
`endif

    sp_shift_align #(
        .WIDTH (WIDTH),
        .COMMA (COMMA)
    ) u_align (
        .i_clk        (clk_32f),
        .i_rst        (reset),
        .i_data       (data_in),
        .i_realign    (w_realign),
        .i_flush      (w_flush),
        .o_word_c     (w_word),
        .o_boundary_c (w_boundary),
        .o_match_c    (w_match),
        .o_hit_c      (w_hit)
    );

    assign data_out    = r_data_out;
    assign valid_out   = r_valid;
    assign word_strobe = r_strobe;
    assign active      = r_active;
    assign comma_cnt   = r_comma_cnt;

    // State and output registers.
    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            r_state     <= INIT;
            r_data_out  <= '0;
            r_valid     <= 1'b0;
            r_strobe    <= 1'b0;
            r_active    <= 1'b0;
            r_comma_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_data_out  <= w_data_nxt;
            r_valid     <= w_valid_nxt;
            r_strobe    <= w_strobe_nxt;
            r_active    <= w_active_nxt;
            r_comma_cnt <= w_cnt_nxt;
        end
    end

`ifdef SERIAL_PARALELO_LOS_EN
    // Boundaries seen in ACTIVE since the last aligned comma.
    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            r_gap <= '0;
        end else begin
            r_gap <= w_gap_nxt;
        end
    end
`endif

    // Alignment FSM: next state, next outputs and shifter control.
    always_comb begin
        w_state_nxt  = r_state;
        w_data_nxt   = r_data_out;
        w_valid_nxt  = 1'b0;
        w_strobe_nxt = 1'b0;
        w_cnt_nxt    = r_comma_cnt;
        w_realign    = 1'b0;
        w_flush      = 1'b0;
`ifdef SERIAL_PARALELO_LOS_EN
        w_gap_nxt    = r_gap;
`endif
        unique case (r_state)
            INIT: begin
                // Bit-sliding search; a hit makes the next bit start a word.
                if (w_hit) begin
                    w_realign   = 1'b1;
                    w_cnt_nxt   = CW'(1);
                    w_state_nxt = (SYNC_COUNT == 1) ? ACTIVE : SYNC;
`ifdef SERIAL_PARALELO_LOS_EN
                    w_gap_nxt   = '0;
`endif
                end
            end
            SYNC: begin
                if (w_boundary) begin
                    w_strobe_nxt = 1'b1;
                    if (w_match) begin
                        w_cnt_nxt = r_comma_cnt + CW'(1);
                        if (w_cnt_nxt == CW'(SYNC_COUNT)) begin
                            w_state_nxt = ACTIVE;
                        end
`ifdef SERIAL_PARALELO_LOS_EN
                        w_gap_nxt = '0;
`endif
                    end else begin
                        // Drop the failed word's bits so the search starts fresh.
                        w_state_nxt = INIT;
                        w_cnt_nxt   = '0;
                        w_flush     = 1'b1;
                    end
                end
            end
            ACTIVE: begin
                if (w_boundary) begin
                    w_strobe_nxt = 1'b1;
                    if (!w_match) begin
                        w_data_nxt  = w_word;
                        w_valid_nxt = 1'b1;
                    end
`ifdef SERIAL_PARALELO_LOS_EN
                    if (w_match) begin
                        w_gap_nxt = '0;
                    end else if ((r_gap + GW'(1)) == GW'(MAX_GAP)) begin
                        // Too long without a comma: payload still delivered, link drops.
                        w_state_nxt = INIT;
                        w_cnt_nxt   = '0;
                        w_flush     = 1'b1;
                        w_gap_nxt   = '0;
                    end else begin
                        w_gap_nxt = r_gap + GW'(1);
                    end
`endif
                end
            end
            default: begin
                w_state_nxt = INIT;
                w_cnt_nxt   = '0;
            end
        endcase
        w_active_nxt = (w_state_nxt == ACTIVE);
    end

endmodule

// File: tb/tb_serial_paralelo_param.sv
// Self-checking bench for serial_paralelo_param (8-bit default and 10-bit variant).
module tb_serial_paralelo_param;

    localparam int unsigned CW = 3;

    typedef struct {
        logic       valid;
        logic [7:0] data;
        logic       act;
        logic [2:0] cnt;
    } exp_t;

    typedef struct {
        logic [7:0] word;
        logic       valid;
        logic [7:0] data;
    } vec_t;

    logic          clk_32f = 1'b0;
    logic          reset;
    logic          data_in;
    logic [7:0]    data_out;
    logic          valid_out;
    logic          word_strobe;
    logic          active;
    logic [CW-1:0] comma_cnt;

    logic          data_in10;
    logic [9:0]    data_out10;
    logic          valid_out10;
    logic          word_strobe10;
    logic          active10;
    logic [0:0]    comma_cnt10;

    exp_t sb_q[$];
    vec_t tbl[9];
    int   n_checks;
    int   n_errors;

    always #5 clk_32f = ~clk_32f;

    serial_paralelo_param #(
        .WIDTH      (8),
        .COMMA      (8'hBC),
        .SYNC_COUNT (4),
        .MAX_GAP    (8)
    ) dut (
        .clk_32f     (clk_32f),
        .reset       (reset),
        .data_in     (data_in),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .word_strobe (word_strobe),
        .active      (active),
        .comma_cnt   (comma_cnt)
    );

    serial_paralelo_param #(
        .WIDTH      (10),
        .COMMA      (10'h17C),
        .SYNC_COUNT (1),
        .MAX_GAP    (64)
    ) dut10 (
        .clk_32f     (clk_32f),
        .reset       (reset),
        .data_in     (data_in10),
        .data_out    (data_out10),
        .valid_out   (valid_out10),
        .word_strobe (word_strobe10),
        .active      (active10),
        .comma_cnt   (comma_cnt10)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk_32f);
        data_in = b;
    endtask

    // Sends the low n bits of w, MSB first.
    task automatic send_bits(input logic [7:0] w, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic send_word(input logic [7:0] w, input logic strobe, input logic valid,
                             input logic [7:0] data, input logic act, input logic [2:0] cnt);
        exp_t e;
        if (strobe) begin
            e.valid = valid;
            e.data  = data;
            e.act   = act;
            e.cnt   = cnt;
            sb_q.push_back(e);
        end
        send_bits(w, 8);
    endtask

    task automatic send_word10(input logic [9:0] w);
        for (int i = 9; i >= 0; i--) begin
            @(negedge clk_32f);
            data_in10 = w[i];
        end
    endtask

    task automatic settle();
        @(posedge clk_32f);
        #1;
    endtask

    // Four aligned commas from INIT; data_out is expected to hold 'held'.
    task automatic sync_up(input logic [7:0] held);
        send_word(8'hBC, 1'b0, 1'b0, held, 1'b0, 3'd0);
        settle();
        chk("init_comma_cnt", 32'(comma_cnt), 32'd1);
        chk("init_active", 32'(active), 32'd0);
        send_word(8'hBC, 1'b1, 1'b0, held, 1'b0, 3'd2);
        send_word(8'hBC, 1'b1, 1'b0, held, 1'b0, 3'd3);
        send_word(8'hBC, 1'b1, 1'b0, held, 1'b1, 3'd4);
        settle();
        chk("sync_active", 32'(active), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_data_out"}, 32'(data_out), 32'd0);
        chk({tag, "_valid_out"}, 32'(valid_out), 32'd0);
        chk({tag, "_word_strobe"}, 32'(word_strobe), 32'd0);
        chk({tag, "_active"}, 32'(active), 32'd0);
        chk({tag, "_comma_cnt"}, 32'(comma_cnt), 32'd0);
    endtask

    // Pops one expectation per word_strobe of the 8-bit instance.
    task automatic monitor();
        exp_t e;
        forever begin
            @(posedge clk_32f);
            #1;
            if (word_strobe === 1'b1) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_strobe", 32'(word_strobe), 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_valid_out", 32'(valid_out), 32'(e.valid));
                    chk("sb_data_out", 32'(data_out), 32'(e.data));
                    chk("sb_active", 32'(active), 32'(e.act));
                    chk("sb_comma_cnt", 32'(comma_cnt), 32'(e.cnt));
                end
            end else if (valid_out !== 1'b0) begin
                chk("stray_valid_out", 32'(valid_out), 32'd0);
            end
        end
    endtask

    initial begin
        logic [7:0] w;
        logic       los_edge;
        logic       exp_act;
        logic [2:0] exp_cnt;

        reset     = 1'b1;
        data_in   = 1'b0;
        data_in10 = 1'b0;
        n_checks  = 0;
        n_errors  = 0;

        tbl[0] = '{8'hA5, 1'b1, 8'hA5};
        tbl[1] = '{8'hBC, 1'b0, 8'hA5};
        tbl[2] = '{8'h3C, 1'b1, 8'h3C};
        tbl[3] = '{8'hFF, 1'b1, 8'hFF};
        tbl[4] = '{8'h00, 1'b1, 8'h00};
        tbl[5] = '{8'hBC, 1'b0, 8'h00};
        tbl[6] = '{8'h0B, 1'b1, 8'h0B};  // 0B,C0 carries a comma straddling the boundary
        tbl[7] = '{8'hC0, 1'b1, 8'hC0};
        tbl[8] = '{8'hBC, 1'b0, 8'hC0};

        fork
            monitor();
        join_none

        // Reset values.
        repeat (3) @(posedge clk_32f);
        #1;
        check_all_zero("reset");
        @(negedge clk_32f);
        reset = 1'b0;

        // Alignment at an arbitrary bit offset.
        send_bits(8'b010, 3);
        sync_up(8'h00);

        // Payload and idle words in ACTIVE.
        for (int i = 0; i < 9; i++) begin
            send_word(tbl[i].word, 1'b1, tbl[i].valid, tbl[i].data, 1'b1, 3'd4);
        end

        // Asynchronous reset at bit 3 of a payload word.
        send_bits(8'b101, 3);
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("async_reset");
        repeat (2) @(negedge clk_32f);
        reset = 1'b0;
        send_bits(8'b00101, 5);
        send_word(8'h55, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0);
        send_word(8'h55, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0);
        settle();
        chk("post_reset_active", 32'(active), 32'd0);
        sync_up(8'h00);

        // SYNC fallback after two commas, then fresh alignment.
        @(negedge clk_32f);
        reset = 1'b1;
        data_in = 1'b0;
        @(negedge clk_32f);
        reset = 1'b0;
        send_bits(8'b010, 3);
        send_word(8'hBC, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0);
        settle();
        chk("fb_comma_cnt1", 32'(comma_cnt), 32'd1);
        send_word(8'hBC, 1'b1, 1'b0, 8'h00, 1'b0, 3'd2);
        send_word(8'h55, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0);
        settle();
        chk("fb_active", 32'(active), 32'd0);
        chk("fb_comma_cnt0", 32'(comma_cnt), 32'd0);
        sync_up(8'h00);

        // Eight payload words without a comma.
        for (int i = 0; i < 8; i++) begin
            w        = 8'(8'h11 * i + 1);
            los_edge = (i == 7);
`ifdef SERIAL_PARALELO_LOS_EN
            exp_act = !los_edge;
            exp_cnt = los_edge ? 3'd0 : 3'd4;
`else
            exp_act = 1'b1;
            exp_cnt = 3'd4;
`endif
            send_word(w, 1'b1, 1'b1, w, exp_act, exp_cnt);
        end
        settle();
        chk("gap_active", 32'(active), 32'(exp_act));
        chk("gap_data_out", 32'(data_out), 32'h78);

        // 10-bit variant, single comma aligns.
        @(negedge clk_32f);
        reset   = 1'b1;
        data_in = 1'b0;
        @(negedge clk_32f);
        reset = 1'b0;
        for (int i = 2; i >= 0; i--) begin
            @(negedge clk_32f);
            data_in10 = (i != 0);
        end
        send_word10(10'h17C);
        settle();
        chk("w10_active", 32'(active10), 32'd1);
        chk("w10_comma_cnt", 32'(comma_cnt10), 32'd1);
        chk("w10_init_strobe", 32'(word_strobe10), 32'd0);
        send_word10(10'h2AA);
        settle();
        chk("w10_strobe", 32'(word_strobe10), 32'd1);
        chk("w10_valid", 32'(valid_out10), 32'd1);
        chk("w10_data", 32'(data_out10), 32'h2AA);
        send_word10(10'h17C);
        settle();
        chk("w10_idle_strobe", 32'(word_strobe10), 32'd1);
        chk("w10_idle_valid", 32'(valid_out10), 32'd0);
        chk("w10_idle_data", 32'(data_out10), 32'h2AA);
        send_word10(10'h0F3);
        settle();
        chk("w10_valid2", 32'(valid_out10), 32'd1);
        chk("w10_data2", 32'(data_out10), 32'h0F3);
        chk("w10_active2", 32'(active10), 32'd1);

        repeat (4) @(posedge clk_32f);
        #1;
        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/serial_paralelo_param.md
Name: serial_paralelo_param

Overview:
- Parametrised successor to the fixed 8-bit serial-to-parallel converter.
- Deserialises an MSB-first bit stream on a single bit-rate clock into WIDTH-bit words.
- Aligns on a configurable comma word and declares link active after SYNC_COUNT consecutive aligned commas.
- Emits a one-cycle word strobe instead of requiring a second word-rate clock; sits between the serial line and the downstream byte/word datapath.

Parameters:
- WIDTH, 8, word width in bits (>=4).
- COMMA, 8'hBC, alignment/idle word; WIDTH bits wide.
- SYNC_COUNT, 4, consecutive aligned commas required to reach ACTIVE (>=1).
- MAX_GAP, 64, words allowed in ACTIVE without a comma before loss of sync (LOS_EN only).

Ports:
- clk_32f  input  1  bit-rate clock; all logic on rising edge; one clock only.
- reset  input  1  asynchronous, active-high; all state cleared immediately on assertion.
- data_in  input  1  serial data, MSB first, sampled every rising edge.
- data_out  output  WIDTH  last non-comma word received in ACTIVE; held between words.
- valid_out  output  1  one-cycle strobe: data_out updated with a payload word this cycle.
- word_strobe  output  1  one-cycle pulse at every aligned word boundary (SYNC and ACTIVE).
- active  output  1  high while in ACTIVE.
- comma_cnt  output  clog2(SYNC_COUNT+1)  aligned commas counted in SYNC; debug.

Behaviour:
- Reset values: data_out=0, valid_out=0, word_strobe=0, active=0, comma_cnt=0, shift register=0, bit_cnt=0, state=INIT.
- Shift register holds WIDTH-1 previous bits. The candidate word is {shift[WIDTH-2:0], data_in}, combinational.
- All outputs are registered and update on the edge that samples the word's last bit (latency 0 cycles after that edge).
- INIT:
  - Compare the candidate word to COMMA every cycle (bit-sliding search).
  - On a match, set bit_cnt=0 (the next bit starts a new word) and comma_cnt=1.
  - Go to SYNC, or to ACTIVE directly if SYNC_COUNT==1.
- bit_cnt counts 0..WIDTH-1 and wraps. A boundary is the cycle with bit_cnt==WIDTH-1.
- SYNC:
  - At each boundary, word_strobe=1.
  - If the candidate word equals COMMA, increment comma_cnt. When the incremented value equals SYNC_COUNT, go to ACTIVE and set active=1 on that same edge.
  - If the candidate word is not COMMA, return to INIT with comma_cnt=0. Do not re-search within the failing word.
- ACTIVE:
  - At each boundary, word_strobe=1.
  - A non-comma word sets data_out=word and valid_out=1 for one cycle.
  - A comma word is idle: valid_out=0 and data_out holds. Alignment is kept; no realignment occurs in ACTIVE.
- comma_cnt saturates at SYNC_COUNT; it holds that value in ACTIVE and is cleared on return to INIT.
- Reset mid-word: all state is discarded and the search restarts in INIT after deassertion; no partial word is emitted.
- A comma straddling a boundary in ACTIVE is ignored; only aligned words are classified.

Optional Feature:
- Macro: SERIAL_PARALELO_LOS_EN.
- Defined:
  - A gap counter counts ACTIVE boundaries since the last aligned comma and is cleared on each comma.
  - On the boundary where the count reaches MAX_GAP, go to INIT: active=0 and comma_cnt=0 on that edge.
  - The payload word on that boundary is still delivered (valid_out=1).
- Undefined: no gap counter exists; ACTIVE persists until reset.

Decomposition:
- Shared package serial_pkg:
  - state enum (INIT, SYNC, ACTIVE);
  - default comma constant K28_5_COMMA=8'hBC;
  - width helper function for comma_cnt.
- One natural sub-module, sp_shift_align: shift register plus bit counter plus comma compare, exporting candidate word, boundary and match. The FSM and output registers stay in the top level.

Test Plan:
- Reset, then 4 aligned 0xBC words starting at an arbitrary bit offset -> active rises on the edge sampling the last bit of the 4th comma; comma_cnt reads 1,2,3,4.
- ACTIVE, then send 0xA5, 0xBC, 0x3C -> valid_out pulses on the 1st and 3rd boundaries only; data_out=0xA5 then 0x3C; word_strobe pulses on all 3.
- SYNC after 2 commas, then send 0x55 -> return to INIT, comma_cnt=0, active stays 0; 4 fresh commas then reach ACTIVE.
- reset asserted at bit 3 of a payload word in ACTIVE -> all outputs 0 immediately (asynchronous); no valid_out after deassertion until 4 new commas.
- WIDTH=10, COMMA=10'h17C, SYNC_COUNT=1 -> a single comma at any offset gives ACTIVE; 10-bit payload 0x2AA is delivered correctly.
- SERIAL_PARALELO_LOS_EN with MAX_GAP=8: ACTIVE, then 8 payload words with no comma -> 8th word valid and active drops on the same edge; with the macro undefined, active stays 1.
